// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
//   state_t        : loader frame-parsing states
//   MAGIC_DEFAULT  : default frame start byte
//   ADDR_BYTES     : number of big-endian base-address bytes in a frame
//   COUNT_BYTES    : number of big-endian word-count bytes in a frame
//   in_frame()     : true while the loader is inside a frame (timeout armed)
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    COUNT,
    DATA_HI,
    DATA_LO,
    CHECK,
    DONE,
    ERR
  } state_t;

  localparam logic [7:0] MAGIC_DEFAULT = 8'hA5;
  localparam int         ADDR_BYTES    = 4;
  localparam int         COUNT_BYTES   = 2;

  function automatic logic in_frame(input state_t s);
    return (s == ADDR) || (s == COUNT) || (s == DATA_HI) ||
           (s == DATA_LO) || (s == CHECK);
  endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// Inter-byte idle watchdog for the program loader.
//   clk     : system clock
//   reset   : synchronous active-high reset
//   clear   : restart the idle count (a byte was accepted)
//   enable  : count idle cycles; the count is held at zero when low
//   expired : high in the cycle that completes TIMEOUT idle cycles
module loader_timeout_counter #(
  parameter int TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear || !enable) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of idle edges already seen, so the edge that
  // would make it TIMEOUT is the one that aborts the frame.
  assign expired = enable && !clear && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader driving the fetch stage's instruction-memory
// write port. A frame is MAGIC, 4 address bytes, 2 count bytes, 2N data
// bytes (high byte first) and an XOR checksum of the data bytes, all
// big-endian. The core is held in reset until a frame checks out.
//   clk             : system clock
//   reset           : synchronous active-high reset
//   in_data/in_valid: input byte stream
//   in_ready        : always 1, the loader never back-pressures
//   write_enable_fm : one-cycle write strobe, one cycle after the low byte
//   write_addr_fm   : word address of the write
//   write_data_fm   : instruction word of the write
//   cpu_hold        : core reset request, released only after a good frame
//   load_done       : sticky, last frame loaded with a good checksum
//   load_error      : sticky, last frame failed (checksum or timeout)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W  = 32,
  parameter int         DATA_W  = 16,
  parameter logic [7:0] MAGIC   = MAGIC_DEFAULT,
  parameter int         TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              write_enable_fm,
  output logic [ADDR_W-1:0] write_addr_fm,
  output logic [DATA_W-1:0] write_data_fm,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  state_t            state;
  state_t            state_n;
  logic              accept;
  logic              tmo_expired;
  logic              we_q;
  logic [1:0]        field_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       count_q;
  logic [7:0]        hi_q;
  logic [7:0]        xor_q;
  logic              field_last_addr;
  logic              field_last_count;

  assign in_ready = 1'b1;
  assign accept   = in_valid;

  assign field_last_addr  = (field_cnt == 2'(ADDR_BYTES - 1));
  assign field_last_count = (field_cnt == 2'(COUNT_BYTES - 1));

  // A registered strobe would otherwise still leave the block during the
  // cycle reset is raised; masking it keeps an aborted word out of memory.
  assign write_enable_fm = we_q & ~reset;

  loader_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (in_frame(state)),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (tmo_expired) begin
      state_n = ERR;
    end else if (accept) begin
      case (state)
        IDLE, DONE, ERR: if (in_data == MAGIC) state_n = ADDR;
        ADDR:            if (field_last_addr) state_n = COUNT;
        COUNT: begin
          if (field_last_count) begin
            state_n = ({count_q[7:0], in_data} != 16'd0) ? DATA_HI : CHECK;
          end
        end
        DATA_HI:         state_n = DATA_LO;
        // count_q still holds the words left including this one.
        DATA_LO:         state_n = (count_q != 16'd1) ? DATA_HI : CHECK;
        CHECK:           state_n = (in_data == xor_q) ? DONE : ERR;
        default:         state_n = IDLE;
      endcase
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q          <= 1'b0;
      write_addr_fm <= '0;
      write_data_fm <= '0;
      cpu_hold      <= 1'b1;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      field_cnt     <= '0;
    end else begin
      we_q <= 1'b0;
      if (tmo_expired) begin
        load_error <= 1'b1;
      end else if (accept) begin
        case (state)
          IDLE, DONE, ERR: begin
            if (in_data == MAGIC) begin
              load_done  <= 1'b0;
              load_error <= 1'b0;
              cpu_hold   <= 1'b1;
              field_cnt  <= '0;
            end
          end
          ADDR:  field_cnt <= field_last_addr  ? 2'd0 : field_cnt + 2'd1;
          COUNT: field_cnt <= field_last_count ? 2'd0 : field_cnt + 2'd1;
          DATA_LO: begin
            write_data_fm <= DATA_W'({hi_q, in_data});
            write_addr_fm <= addr_q;
            we_q          <= 1'b1;
          end
          CHECK: begin
            if (in_data == xor_q) begin
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              load_error <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Frame datapath registers; every one is loaded before it is used.
  always_ff @(posedge clk) begin
    if (accept) begin
      case (state)
        IDLE, DONE, ERR: if (in_data == MAGIC) xor_q <= 8'h00;
        ADDR:    addr_q  <= {addr_q[ADDR_W-9:0], in_data};
        COUNT:   count_q <= {count_q[7:0], in_data};
        DATA_HI: begin
          hi_q  <= in_data;
          xor_q <= xor_q ^ in_data;
        end
        DATA_LO: begin
          xor_q   <= xor_q ^ in_data;
          addr_q  <= addr_q + ADDR_W'(1);
          count_q <= count_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: drives framed byte streams, records
// every write strobe seen on the fetch port and checks it against writes
// predicted when each frame is built.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        write_enable_fm;
  logic [31:0] write_addr_fm;
  logic [15:0] write_data_fm;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  imem_loader #(
    .ADDR_W  (32),
    .DATA_W  (16),
    .MAGIC   (8'hA5),
    .TIMEOUT (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .write_enable_fm (write_enable_fm),
    .write_addr_fm   (write_addr_fm),
    .write_data_fm   (write_data_fm),
    .cpu_hold        (cpu_hold),
    .load_done       (load_done),
    .load_error      (load_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [47:0] exp_q[$];
  logic [47:0] obs_q[$];
  int          obs_cyc[$];
  logic [7:0]  tx[$];
  logic [15:0] wq[$];
  int          n_chk = 0;
  int          n_fail = 0;

  always @(negedge clk) begin
    if (write_enable_fm === 1'b1) begin
      obs_q.push_back({write_addr_fm, write_data_fm});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic send_n(input int k);
    for (int i = 0; i < k && tx.size() > 0; i++) begin
      in_data  = tx.pop_front();
      in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queues the bytes of a frame carrying the words in wq and predicts the
  // writes it produces; the checksum is computed here unless forced.
  task automatic build_frame(input logic [31:0] base, input bit force_cs,
                             input logic [7:0] cs_val);
    logic [7:0]  x;
    logic [31:0] a;
    logic [15:0] n;
    x = 8'h00;
    a = base;
    n = 16'(wq.size());
    tx.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) tx.push_back(base[8*i +: 8]);
    tx.push_back(n[15:8]);
    tx.push_back(n[7:0]);
    foreach (wq[i]) begin
      tx.push_back(wq[i][15:8]);
      tx.push_back(wq[i][7:0]);
      x = x ^ wq[i][15:8] ^ wq[i][7:0];
      exp_q.push_back({a, wq[i]});
      a = a + 32'd1;
    end
    tx.push_back(force_cs ? cs_val : x);
    wq.delete();
  endtask

  task automatic test_reset();
    n_chk++;
    if (write_enable_fm !== 1'b0) begin
      n_fail++; $display("FAIL reset_we: got %b want 0", write_enable_fm);
    end
    n_chk++;
    if (write_addr_fm !== 32'h0 || write_data_fm !== 16'h0) begin
      n_fail++; $display("FAIL reset_addr_data: got %h/%h want 0/0", write_addr_fm, write_data_fm);
    end
    n_chk++;
    if ({cpu_hold, load_done, load_error} !== 3'b100) begin
      n_fail++; $display("FAIL reset_flags: got hold/done/err %b want 100", {cpu_hold, load_done, load_error});
    end
    n_chk++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    n_chk++;
    if (dut.state !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want IDLE", dut.state);
    end
  endtask

  task automatic test_good_frame();
    logic [47:0] e, o;
    wq.push_back(16'h1234);
    wq.push_back(16'hABCD);
    build_frame(32'h0000_0010, 1'b0, 8'h00);
    send_n(tx.size());
    idle(3);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL good_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL good_write: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    n_chk++;
    if ({cpu_hold, load_done, load_error} !== 3'b010) begin
      n_fail++; $display("FAIL good_flags: got hold/done/err %b want 010", {cpu_hold, load_done, load_error});
    end
  endtask

  task automatic test_bad_checksum();
    logic [47:0] e, o;
    wq.push_back(16'h1234);
    wq.push_back(16'hABCD);
    build_frame(32'h0000_0010, 1'b1, 8'h00);
    send_n(tx.size());
    idle(3);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL badcs_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL badcs_write: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    n_chk++;
    if ({cpu_hold, load_done, load_error} !== 3'b101) begin
      n_fail++; $display("FAIL badcs_flags: got hold/done/err %b want 101", {cpu_hold, load_done, load_error});
    end
  endtask

  task automatic test_garbage_empty();
    tx.push_back(8'h00);
    tx.push_back(8'hFF);
    tx.push_back(8'h5A);
    build_frame(32'h0000_0000, 1'b0, 8'h00);
    send_n(tx.size());
    idle(3);
    n_chk++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL empty_nwrites: got %0d want 0", obs_q.size());
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    n_chk++;
    if ({cpu_hold, load_done, load_error} !== 3'b010) begin
      n_fail++; $display("FAIL empty_flags: got hold/done/err %b want 010", {cpu_hold, load_done, load_error});
    end
  endtask

  task automatic test_wrap();
    logic [47:0] e, o;
    wq.push_back(16'h0001);
    wq.push_back(16'h0002);
    build_frame(32'hFFFF_FFFF, 1'b0, 8'h00);
    send_n(tx.size());
    idle(3);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wrap_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_write: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    n_chk++;
    if ({cpu_hold, load_done, load_error} !== 3'b010) begin
      n_fail++; $display("FAIL wrap_flags: got hold/done/err %b want 010", {cpu_hold, load_done, load_error});
    end
  endtask

  // Contiguous bytes, including MAGIC values inside the data payload.
  task automatic test_back_to_back();
    logic [47:0] e, o;
    wq.push_back(16'hA5A5);
    wq.push_back(16'h0000);
    wq.push_back(16'h1234);
    wq.push_back(16'hFFFF);
    build_frame(32'h0000_0100, 1'b0, 8'h00);
    send_n(tx.size());
    idle(3);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 1; i < obs_cyc.size(); i++) begin
      n_chk++;
      if (obs_cyc[i] - obs_cyc[i-1] != 2) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d cycles want 2", obs_cyc[i] - obs_cyc[i-1]);
      end
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_write: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    n_chk++;
    if ({cpu_hold, load_done, load_error} !== 3'b010) begin
      n_fail++; $display("FAIL b2b_flags: got hold/done/err %b want 010", {cpu_hold, load_done, load_error});
    end
  endtask

  // A gap well inside the idle limit must not abort the frame.
  task automatic test_short_gap();
    logic [47:0] e, o;
    wq.push_back(16'h5566);
    wq.push_back(16'h7788);
    build_frame(32'h0000_0200, 1'b0, 8'h00);
    send_n(8);
    idle(TMO - 4);
    send_n(tx.size());
    idle(3);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL gap_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL gap_write: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    n_chk++;
    if ({cpu_hold, load_done, load_error} !== 3'b010) begin
      n_fail++; $display("FAIL gap_flags: got hold/done/err %b want 010", {cpu_hold, load_done, load_error});
    end
  endtask

  task automatic test_timeout();
    logic [47:0] e, o;
    tx = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    exp_q.push_back({32'h0000_0020, 16'h1122});
    send_n(tx.size());
    idle(TMO + 4);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL tmo_nwrites: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL tmo_write: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    n_chk++;
    if ({cpu_hold, load_done, load_error} !== 3'b101) begin
      n_fail++; $display("FAIL tmo_flags: got hold/done/err %b want 101", {cpu_hold, load_done, load_error});
    end
    n_chk++;
    if (dut.state !== ERR) begin
      n_fail++; $display("FAIL tmo_state: got %0d want ERR", dut.state);
    end
  endtask

  task automatic test_reset_mid();
    tx = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h01, 8'hAB, 8'hCD};
    send_n(tx.size());
    reset = 1'b1;
    @(negedge clk);
    n_chk++;
    if (write_enable_fm !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_strobe: got %b want 0", write_enable_fm);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_chk++;
    if ({cpu_hold, load_done, load_error} !== 3'b100) begin
      n_fail++; $display("FAIL rstmid_flags: got hold/done/err %b want 100", {cpu_hold, load_done, load_error});
    end
    n_chk++;
    if (write_addr_fm !== 32'h0 || write_data_fm !== 16'h0) begin
      n_fail++; $display("FAIL rstmid_addr_data: got %h/%h want 0/0", write_addr_fm, write_data_fm);
    end
    n_chk++;
    if (dut.state !== IDLE) begin
      n_fail++; $display("FAIL rstmid_state: got %0d want IDLE", dut.state);
    end
    idle(3);
    n_chk++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL rstmid_nwrites: got %0d want 0", obs_q.size());
    end
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  initial begin
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    #1;
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_garbage_empty();
    test_wrap();
    test_back_to_back();
    test_short_gap();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
